t09_ssscan: RTL

T09_SSSCAN -- requirements
Module: t09_ssscan

---
 rtl/t09_ssscan.sv | 86 ++++++++
 1 files changed

// File: rtl/t09_ssscan.sv
// Eight-digit multiplexed hex display scanner with double-buffered load.
// Optional leading-zero blanking is enabled by defining T09_SSSCAN_LZB_EN.
module t09_ssscan #(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_i,
    input  logic        load_i,
    output logic        ready_o,
    output logic [3:0]  digit_o,
    output logic        dig_en_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] disp_q, disp_d;
    logic [31:0] pend_q, pend_d;
    logic        pvld_q, pvld_d;
    logic        frame_q, frame_d;
    logic        tick, wrap, accept;

    always_comb begin
        tick    = (cnt_q == LAST);
        wrap    = tick && (idx_q == 3'd7);
        accept  = load_i && !pvld_q;
        cnt_d   = tick ? 16'd0 : 16'(cnt_q + 16'd1);
        idx_d   = tick ? 3'(idx_q + 3'd1) : idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        frame_d = wrap;
        // The copy uses the old pend, so a load on the wrap waits a frame.
        if (wrap && pvld_q) begin
            disp_d = pend_q;
            pvld_d = 1'b0;
        end
        if (accept) begin
            pend_d = value_i;
            pvld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        ready_o = !pvld_q;
        an_o    = (cnt_q == 16'd0) ? 8'h00 : (8'h01 << idx_q);
        digit_o = disp_q[4*idx_q +: 4];
        frame_o = frame_q;
    end

`ifdef T09_SSSCAN_LZB_EN
    logic [7:0] nz;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nz[i] = |disp_q[4*i +: 4];
        end
        dig_en_o = (idx_q == 3'd0) || (|(nz >> idx_q));
    end
`else
    assign dig_en_o = 1'b1;
`endif

endmodule
